// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - streams a wrapping address range of a p_ram out over valid/ready; optional RAM_READER_CHECKSUM_EN adds an XOR checksum port
module ram_burst_reader #(
  parameter int BIT_WIDTH = 1,
  parameter int SEL_WIDTH = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SEL_WIDTH-1:0] start_address,
  input  logic [SEL_WIDTH:0]   length,
  output logic [SEL_WIDTH-1:0] address,
  input  logic [BIT_WIDTH-1:0] in,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
`ifdef RAM_READER_CHECKSUM_EN
  ,
  output logic [BIT_WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] address_q, address_d;
  logic [SEL_WIDTH:0]   fetch_rem_q, fetch_rem_d;
  logic [SEL_WIDTH:0]   deliver_rem_q, deliver_rem_d;
  logic [BIT_WIDTH-1:0] head_q, head_d;
  logic [BIT_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]           count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pop;
  logic                 fetch;
`ifdef RAM_READER_CHECKSUM_EN
  logic [BIT_WIDTH-1:0] checksum_q, checksum_d;
`endif

  // Next-state logic: burst sequencing, address walk and the 2-entry output FIFO
  always_comb begin
    state_d       = state_q;
    address_d     = address_q;
    fetch_rem_d   = fetch_rem_q;
    deliver_rem_d = deliver_rem_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    done_d        = 1'b0;
`ifdef RAM_READER_CHECKSUM_EN
    checksum_d    = checksum_q;
`endif

    pop   = valid_q & out_ready;
    // A slot is free either because the FIFO is not full or the head leaves this cycle
    fetch = (state_q == READ) && (fetch_rem_q != '0) && ((count_q != 2'd2) || pop);

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef RAM_READER_CHECKSUM_EN
          checksum_d = '0;
`endif
          if (length != '0) begin
            address_d     = start_address;
            fetch_rem_d   = length;
            deliver_rem_d = length;
            state_d       = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (fetch && (fetch_rem_q == (SEL_WIDTH+1)'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (deliver_rem_q == (SEL_WIDTH+1)'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fetch) begin
      address_d   = address_q + SEL_WIDTH'(1);
      fetch_rem_d = fetch_rem_q - (SEL_WIDTH+1)'(1);
    end

    if (pop) begin
      deliver_rem_d = deliver_rem_q - (SEL_WIDTH+1)'(1);
`ifdef RAM_READER_CHECKSUM_EN
      checksum_d    = checksum_q ^ head_q;
`endif
    end

    // FIFO: head is always the oldest word; a push lands in the first free slot
    case ({fetch, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in;
        else                 tail_d = in;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in;
        end else begin
          head_d = tail_q;
          tail_d = in;
        end
      end
      default: ;
    endcase

    valid_d = (count_d != 2'd0);
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      address_q     <= '0;
      fetch_rem_q   <= '0;
      deliver_rem_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= 2'd0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef RAM_READER_CHECKSUM_EN
      checksum_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      fetch_rem_q   <= fetch_rem_d;
      deliver_rem_q <= deliver_rem_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef RAM_READER_CHECKSUM_EN
      checksum_q    <= checksum_d;
`endif
    end
  end

  assign address   = address_q;
  assign out       = head_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef RAM_READER_CHECKSUM_EN
  assign checksum  = checksum_q;
`endif

endmodule
